// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer path: event field positions, sequencer
// state encodings and chromatic note codes. Also a helper that pulls the
// duration out of an event word, with a zero duration promoted to one tick.
package buzzer_pkg;

    // Event word layout: [15] sound/rest, [14:8] duration, [7:4] octave, [3:0] note
    localparam int EVT_NOTE_LSB = 0;
    localparam int EVT_NOTE_MSB = 3;
    localparam int EVT_OCT_LSB  = 4;
    localparam int EVT_OCT_MSB  = 7;
    localparam int EVT_DUR_LSB  = 8;
    localparam int EVT_DUR_MSB  = 14;
    localparam int EVT_SND      = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } seq_state_e;

    localparam logic [3:0] NOTE_C  = 4'd0;
    localparam logic [3:0] NOTE_CS = 4'd1;
    localparam logic [3:0] NOTE_D  = 4'd2;
    localparam logic [3:0] NOTE_DS = 4'd3;
    localparam logic [3:0] NOTE_E  = 4'd4;
    localparam logic [3:0] NOTE_F  = 4'd5;
    localparam logic [3:0] NOTE_FS = 4'd6;
    localparam logic [3:0] NOTE_G  = 4'd7;
    localparam logic [3:0] NOTE_GS = 4'd8;
    localparam logic [3:0] NOTE_A  = 4'd9;
    localparam logic [3:0] NOTE_AS = 4'd10;
    localparam logic [3:0] NOTE_B  = 4'd11;

    // A zero duration would never expire, so it plays as a single tick.
    function automatic logic [6:0] evt_dur(input logic [15:0] ev);
        logic [6:0] d;
        d = ev[EVT_DUR_MSB:EVT_DUR_LSB];
        return (d == 7'd0) ? 7'd1 : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding queued note events.
// Ports: clk/rst (async high reset), clr (synchronous empty), push/wdata,
// pop, rdata (current head), count (occupancy), full, empty.
// A push while full and a pop while empty are ignored; there is no
// fall-through, so data pushed into an empty FIFO is poppable next cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q];
    assign count   = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            // Pointers are AW bits wide so they wrap modulo DEPTH for free.
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage needs no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: plays queued timed note events into the buzzer.
// Ports: clk/rst (async high reset); wr_valid/wr_data/wr_ready event write
// port; play_en (consume level); flush (empty queue, abort event);
// buzzer_note/buzzer_en to the buzzer; busy (PLAY or GAP); fifo_count;
// underrun (sticky, queue ran dry while playing, cleared by flush).
module note_sequencer
    import buzzer_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int DEPTH     = 16,
    parameter int GAP_TICKS = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    input  logic [15:0]             wr_data,
    output logic                    wr_ready,
    input  logic                    play_en,
    input  logic                    flush,
    output logic [7:0]              buzzer_note,
    output logic                    buzzer_en,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    underrun
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    seq_state_e     state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [6:0]     dur_q, dur_d;
    logic [15:0]    gap_q, gap_d;
    logic [7:0]     note_q, note_d;
    logic           en_q, en_d;
    logic           under_q, under_d;

    logic [15:0]    head;
    logic           full, empty, pop, tick, load, done;

    sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (wr_valid && !flush),
        .wdata (wr_data),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign wr_ready    = !full;
    assign buzzer_note = note_q;
    assign buzzer_en   = en_q;
    assign busy        = (state_q != IDLE);
    assign underrun    = under_q;
    assign tick        = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        note_d  = note_q;
        en_d    = en_q;
        under_d = under_q;
        pop     = 1'b0;
        load    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            IDLE: load = play_en && !empty;
            PLAY: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    dur_d = dur_q - 1'b1;
                    if (dur_q == 7'd1) begin
                        en_d = 1'b0;
                        if (GAP_TICKS > 0) begin
                            state_d = GAP;
                            gap_d   = '0;
                        end else begin
                            done = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    gap_d = gap_q + 16'd1;
                    if (gap_q == 16'(GAP_TICKS - 1)) done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // End of an event: chain straight into the next one if available.
        if (done) begin
            if (play_en && !empty) begin
                load = 1'b1;
            end else begin
                state_d = IDLE;
                en_d    = 1'b0;
                if (play_en) under_d = 1'b1;
            end
        end

        if (load) begin
            pop     = 1'b1;
            state_d = PLAY;
            note_d  = head[EVT_OCT_MSB:EVT_NOTE_LSB];
            en_d    = head[EVT_SND];
            presc_d = '0;
            dur_d   = evt_dur(head);
        end

        // Flush wins over everything; note output keeps its last value.
        if (flush) begin
            pop     = 1'b0;
            state_d = IDLE;
            en_d    = 1'b0;
            under_d = 1'b0;
            presc_d = '0;
            dur_d   = '0;
            gap_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
            note_q  <= '0;
            en_q    <= 1'b0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            note_q  <= note_d;
            en_q    <= en_d;
            under_q <= under_d;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer. Main instance: TICK_DIV=4, DEPTH=4,
// GAP_TICKS=0. Second instance with GAP_TICKS=2 covers the gap timing.
module tb_note_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid, play_en, flush;
    logic [15:0] wr_data;
    logic        wr_ready, buzzer_en, busy, underrun;
    logic [7:0]  buzzer_note;
    logic [2:0]  fifo_count;

    logic        wr_valid2, play_en2, flush2;
    logic [15:0] wr_data2;
    logic        wr_ready2, buzzer_en2, busy2, underrun2;
    logic [7:0]  buzzer_note2;
    logic [2:0]  fifo_count2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    note_sequencer #(.TICK_DIV(4), .DEPTH(4), .GAP_TICKS(0)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .play_en(play_en), .flush(flush),
        .buzzer_note(buzzer_note), .buzzer_en(buzzer_en), .busy(busy),
        .fifo_count(fifo_count), .underrun(underrun)
    );

    note_sequencer #(.TICK_DIV(4), .DEPTH(4), .GAP_TICKS(2)) dut_gap (
        .clk(clk), .rst(rst), .wr_valid(wr_valid2), .wr_data(wr_data2),
        .wr_ready(wr_ready2), .play_en(play_en2), .flush(flush2),
        .buzzer_note(buzzer_note2), .buzzer_en(buzzer_en2), .busy(busy2),
        .fifo_count(fifo_count2), .underrun(underrun2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; sample and drive 1 ns later.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    logic [15:0] seq3 [3];
    logic [15:0] seq4 [5];
    int n_on;

    initial begin
        rst = 1'b1;
        wr_valid = 0; wr_data = '0; play_en = 0; flush = 0;
        wr_valid2 = 0; wr_data2 = '0; play_en2 = 0; flush2 = 0;
        #12;
        chk("rst_state", {buzzer_note, buzzer_en, busy, fifo_count, underrun, wr_ready},
            {8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        step();

        // 1: reset in the middle of a played event
        play_en = 1; wr_valid = 1; wr_data = 16'h8A49;
        step();
        wr_valid = 0;
        step(3);
        chk("t1_playing", {buzzer_note, buzzer_en, busy}, {8'h49, 1'b1, 1'b1});
        #3 rst = 1'b1;
        #1;
        chk("t1_async_rst", {buzzer_note, buzzer_en, busy, fifo_count, underrun},
            {8'h00, 1'b0, 1'b0, 3'd0, 1'b0});
        play_en = 0;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("t1_after_rel", {fifo_count, busy, buzzer_en}, {3'd0, 1'b0, 1'b0});

        // 2: single A4 event, 5 ticks -> 20 cycles of sound
        play_en = 1; wr_valid = 1; wr_data = 16'h8549;
        step();
        wr_valid = 0;
        chk("t2_accept", {fifo_count, buzzer_en}, {3'd1, 1'b0});
        step();
        chk("t2_start", {buzzer_note, buzzer_en, fifo_count}, {8'h49, 1'b1, 3'd0});
        n_on = 1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (buzzer_en) n_on++;
        end
        chk("t2_on_cycles", n_on, 20);
        chk("t2_end", {busy, underrun, buzzer_note}, {1'b0, 1'b1, 8'h49});

        // 3: three queued 2-tick events play back-to-back
        play_en = 0;
        do_flush();
        chk("t3_flush_clr", underrun, 1'b0);
        seq3[0] = 16'h8242; seq3[1] = 16'h0240; seq3[2] = 16'h8243;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_data = seq3[i];
            step();
        end
        wr_valid = 0;
        chk("t3_count", fifo_count, 3);
        play_en = 1;
        for (int i = 0; i < 24; i++) begin
            step();
            chk($sformatf("t3_c%0d", i), {busy, buzzer_en, buzzer_note},
                (i < 8)  ? {1'b1, 1'b1, 8'h42} :
                (i < 16) ? {1'b1, 1'b0, 8'h40} : {1'b1, 1'b1, 8'h43});
        end
        step();
        chk("t3_idle", {busy, buzzer_en, underrun}, {1'b0, 1'b0, 1'b1});

        // 4: overfill, then push refused in the same cycle as a pop while full
        play_en = 0;
        do_flush();
        seq4[0] = 16'h8141; seq4[1] = 16'h8142; seq4[2] = 16'h8143;
        seq4[3] = 16'h8144; seq4[4] = 16'h8145;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1; wr_data = seq4[i];
            step();
        end
        chk("t4_full", {wr_ready, fifo_count}, {1'b0, 3'd4});
        wr_data = 16'h8146; play_en = 1;
        step();
        wr_valid = 0;
        chk("t4_pop_no_push", {fifo_count, buzzer_note, buzzer_en}, {3'd3, 8'h41, 1'b1});
        step(4);
        chk("t4_ev2", buzzer_note, 8'h42);
        step(4);
        chk("t4_ev3", buzzer_note, 8'h43);
        step(4);
        chk("t4_ev4", buzzer_note, 8'h44);
        step(4);
        chk("t4_drained", {busy, buzzer_en, buzzer_note, fifo_count}, {1'b0, 1'b0, 8'h44, 3'd0});

        // 6: zero duration plays one tick; flush mid-event drops a coincident write
        chk("t6_under_pre", underrun, 1'b1);
        play_en = 0;
        seq3[0] = 16'h8041; seq3[1] = 16'h8242; seq3[2] = 16'h8243;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_data = seq3[i];
            step();
        end
        wr_valid = 0;
        play_en = 1;
        step();
        chk("t6_ev1", {buzzer_note, buzzer_en}, {8'h41, 1'b1});
        step(3);
        chk("t6_ev1_end", buzzer_note, 8'h41);
        step();
        chk("t6_ev2", {buzzer_note, buzzer_en, fifo_count}, {8'h42, 1'b1, 3'd1});
        step(2);
        flush = 1; wr_valid = 1; wr_data = 16'h8147;
        step();
        flush = 0; wr_valid = 0;
        chk("t6_flushed", {buzzer_en, busy, fifo_count, underrun}, {1'b0, 1'b0, 3'd0, 1'b0});
        step(3);
        chk("t6_stay_empty", {buzzer_en, busy, fifo_count}, {1'b0, 1'b0, 3'd0});
        play_en = 0;

        // 5: GAP_TICKS=2 with two 1-tick events
        for (int i = 0; i < 2; i++) begin
            wr_valid2 = 1; wr_data2 = (i == 0) ? 16'h8141 : 16'h8142;
            step();
        end
        wr_valid2 = 0;
        play_en2 = 1;
        for (int i = 0; i < 24; i++) begin
            step();
            chk($sformatf("t5_c%0d", i), {busy2, buzzer_en2},
                (i < 4)  ? 2'b11 : (i < 12) ? 2'b10 :
                (i < 16) ? 2'b11 : 2'b10);
        end
        chk("t5_note2", buzzer_note2, 8'h42);
        step();
        chk("t5_idle", {busy2, buzzer_en2, underrun2}, {1'b0, 1'b0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
